// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared constants and state encodings for the UART
// instruction-memory bootloader (framing FSM and UART receiver).
package imem_loader_pkg;

   // First byte of every load frame.
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   // Framing FSM states.
   typedef enum logic [2:0] {
      WAIT_SYNC,
      GET_LEN,
      GET_DATA,
      GET_CKSUM,
      DONE
   } ldr_state_t;

   // UART receiver states.
   typedef enum logic [1:0] {
      IDLE,
      START,
      BITS,
      STOP
   } rx_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: instruction-memory write port (write strobe, word index,
// word data). The loader is the master, the memory is the slave.
interface imem_loader_if;
   import imem_loader_pkg::*;

   logic        write;
   logic [31:0] addr_in;
   logic [31:0] data;

   modport master (output write, output addr_in, output data);
   modport slave  (input  write, input  addr_in, input  data);

endinterface

// File: rtl/imem_loader_uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver. Synchronises rx, times the start bit to
// its centre, samples 8 data bits LSB first and checks the stop bit.
// Emits a one-cycle byte_valid on a good stop bit, frame_err on a bad one.
module uart_rx_byte
   import imem_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

   logic          rx_meta, rx_s, rx_prev;
   rx_state_t     state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0]    bit_idx, bit_idx_nx;
   logic [7:0]    shreg, shreg_nx;
   logic          valid_nx, ferr_nx;

   // Two-flop synchroniser plus one delayed copy for falling-edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   // Receiver state, bit timing counter and output pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         bit_idx    <= bit_idx_nx;
         byte_valid <= valid_nx;
         frame_err  <= ferr_nx;
      end
   end

   // Shift register holds data only, so it carries no reset.
   always_ff @(posedge clk) begin
      shreg <= shreg_nx;
   end

   // Next-state logic: half a bit to the start centre, then full bits.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      bit_idx_nx = bit_idx;
      shreg_nx   = shreg;
      valid_nx   = 1'b0;
      ferr_nx    = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx     = '0;
            bit_idx_nx = '0;
            if (rx_prev && !rx_s) state_nx = START;
         end
         START: begin
            if (cnt == HALF_CNT) begin
               cnt_nx   = '0;
               // A line that is high again at mid-start was a glitch.
               state_nx = rx_s ? IDLE : BITS;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         BITS: begin
            if (cnt == FULL_CNT) begin
               cnt_nx   = '0;
               shreg_nx = {rx_s, shreg[7:1]};
               if (bit_idx == 3'd7) state_nx = STOP;
               else                 bit_idx_nx = bit_idx + 3'd1;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         STOP: begin
            if (cnt == FULL_CNT) begin
               cnt_nx   = '0;
               state_nx = IDLE;
               if (rx_s) valid_nx = 1'b1;
               else      ferr_nx  = 1'b1;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign rx_byte = shreg;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: UART bootloader. Parses frames of
//   A5, N (1..DEPTH), 4*N little-endian payload bytes [, checksum]
// and writes one imem word per 4 payload bytes while holding the core off.
// Optional feature macro: IMEM_LOADER_CKSUM_EN adds a trailing checksum byte
// (two's complement of N plus all payload bytes, mod 256).
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int DEPTH        = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          rx,
   imem_loader_if.master imem,
   output logic          cpu_hold,
   output logic          busy,
   output logic          error
);

   localparam int WCW = $clog2(DEPTH) + 1;
   localparam logic [7:0] DEPTH_B = 8'(DEPTH);

   logic       byte_valid, frame_err;
   logic [7:0] rx_byte;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .byte_valid (byte_valid),
      .rx_byte    (rx_byte),
      .frame_err  (frame_err)
   );

   ldr_state_t     state, state_nx;
   logic [1:0]     byte_cnt, byte_cnt_nx;
   logic [WCW-1:0] word_cnt, word_cnt_nx;
   logic [WCW-1:0] len, len_nx;
   logic [23:0]    asm_word, asm_word_nx;
   logic           write_r, write_nx;
   logic [31:0]    addr_r, addr_nx;
   logic [31:0]    data_r, data_nx;
   logic           hold_r, hold_nx;
   logic           error_r, error_nx;
`ifdef IMEM_LOADER_CKSUM_EN
   logic [7:0]     cksum, cksum_nx;
`endif

   // FSM state, counters and registered imem/status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= WAIT_SYNC;
         byte_cnt <= '0;
         word_cnt <= '0;
         len      <= '0;
         write_r  <= 1'b0;
         addr_r   <= '0;
         data_r   <= '0;
         hold_r   <= 1'b0;
         error_r  <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
         cksum    <= '0;
`endif
      end else begin
         state    <= state_nx;
         byte_cnt <= byte_cnt_nx;
         word_cnt <= word_cnt_nx;
         len      <= len_nx;
         write_r  <= write_nx;
         addr_r   <= addr_nx;
         data_r   <= data_nx;
         hold_r   <= hold_nx;
         error_r  <= error_nx;
`ifdef IMEM_LOADER_CKSUM_EN
         cksum    <= cksum_nx;
`endif
      end
   end

   // Lower three bytes of the word being assembled; pure data, no reset.
   always_ff @(posedge clk) begin
      asm_word <= asm_word_nx;
   end

   // Framing FSM: next state, word assembly and output strobes.
   always_comb begin
      state_nx    = state;
      byte_cnt_nx = byte_cnt;
      word_cnt_nx = word_cnt;
      len_nx      = len;
      asm_word_nx = asm_word;
      write_nx    = 1'b0;
      addr_nx     = addr_r;
      data_nx     = data_r;
      hold_nx     = hold_r;
      error_nx    = error_r;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_nx    = cksum;
`endif
      if (frame_err) begin
         // A broken byte aborts the frame. cpu_hold is left as it is: words
         // may already be in imem, so only a clean frame may release the core.
         error_nx = 1'b1;
         state_nx = WAIT_SYNC;
      end else begin
         case (state)
            WAIT_SYNC: begin
               if (byte_valid && rx_byte == SYNC_BYTE) begin
                  state_nx = GET_LEN;
                  hold_nx  = 1'b1;
                  error_nx = 1'b0;
               end
            end
            GET_LEN: begin
               if (byte_valid) begin
                  if (rx_byte == 8'd0 || rx_byte > DEPTH_B) begin
                     error_nx = 1'b1;
                     hold_nx  = 1'b0;
                     state_nx = WAIT_SYNC;
                  end else begin
                     len_nx      = rx_byte[WCW-1:0];
                     byte_cnt_nx = '0;
                     word_cnt_nx = '0;
                     state_nx    = GET_DATA;
`ifdef IMEM_LOADER_CKSUM_EN
                     cksum_nx    = rx_byte;
`endif
                  end
               end
            end
            GET_DATA: begin
               if (byte_valid) begin
                  byte_cnt_nx = byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
                  cksum_nx    = cksum + rx_byte;
`endif
                  case (byte_cnt)
                     2'd0: asm_word_nx[7:0]   = rx_byte;
                     2'd1: asm_word_nx[15:8]  = rx_byte;
                     2'd2: asm_word_nx[23:16] = rx_byte;
                     default: begin
                        write_nx    = 1'b1;
                        data_nx     = {rx_byte, asm_word};
                        addr_nx     = 32'(word_cnt);
                        word_cnt_nx = word_cnt + WCW'(1);
                        if (word_cnt == len - WCW'(1)) begin
`ifdef IMEM_LOADER_CKSUM_EN
                           state_nx = GET_CKSUM;
`else
                           state_nx = DONE;
`endif
                        end
                     end
                  endcase
               end
            end
`ifdef IMEM_LOADER_CKSUM_EN
            GET_CKSUM: begin
               if (byte_valid) begin
                  if (8'(cksum + rx_byte) == 8'd0) begin
                     state_nx = DONE;
                  end else begin
                     // Bad image already sits in imem: keep the core held.
                     error_nx = 1'b1;
                     state_nx = WAIT_SYNC;
                  end
               end
            end
`endif
            DONE: begin
               hold_nx  = 1'b0;
               state_nx = WAIT_SYNC;
            end
            default: state_nx = WAIT_SYNC;
         endcase
      end
   end

   assign imem.write   = write_r;
   assign imem.addr_in = addr_r;
   assign imem.data    = data_r;
   assign cpu_hold     = hold_r;
   assign error        = error_r;
   assign busy         = (state != WAIT_SYNC);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frame vectors for imem_loader, plus hand-written
// sequences for reset, mid-frame reset and the optional checksum.
module tb_imem_loader;

   localparam int CPB   = 16;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic reset;
   logic rx;
   logic cpu_hold, busy, error;

   imem_loader_if bus ();

   imem_loader #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .rx       (rx),
      .imem     (bus),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .error    (error)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Write-port monitor, sampled on the falling edge.
   int          cyc = 0;
   logic        prev_write = 1'b0;
   logic        prev_hold = 1'b0;
   int          long_pulses = 0;
   int          last_write_cyc = -100;
   int          hold_fall_cyc = -100;
   logic [31:0] wa[$];
   logic [31:0] wd[$];

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (bus.write === 1'b1) begin
         wa.push_back(bus.addr_in);
         wd.push_back(bus.data);
         last_write_cyc = cyc;
         if (prev_write === 1'b1) long_pulses = long_pulses + 1;
      end
      if (prev_hold === 1'b1 && cpu_hold === 1'b0) hold_fall_cyc = cyc;
      prev_write = bus.write;
      prev_hold  = cpu_hold;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors = vectors + 1;
      if (act !== exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic clear_log();
      wa.delete();
      wd.delete();
      long_pulses    = 0;
      last_write_cyc = -100;
      hold_fall_cyc  = -100;
   endtask

   // One 8N1 character; stop_ok=0 forces the stop bit low.
   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_ok;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   typedef struct {
      logic [95:0] bytes;     // up to 12 bytes, first byte in the top octet
      int          n;
      int          bad_stop;  // byte index with a low stop bit, -1 = none
      bit          add_ck;    // append a checksum when the option is built
      int          gen_words; // extra generated payload words {33,22,11,i}
      int          exp_writes;
      logic [31:0] exp_fd;
      logic [31:0] exp_la;
      logic [31:0] exp_ld;
      bit          exp_err;
      bit          chk_hold;
      bit          exp_hold;
   } vec_t;

   function automatic vec_t mk(logic [95:0] bytes, int n, int bad, bit ck, int gen,
                               int nw, logic [31:0] fd, logic [31:0] la,
                               logic [31:0] ld, bit err, bit chkh, bit hold);
      vec_t v;
      v.bytes = bytes; v.n = n; v.bad_stop = bad; v.add_ck = ck; v.gen_words = gen;
      v.exp_writes = nw; v.exp_fd = fd; v.exp_la = la; v.exp_ld = ld;
      v.exp_err = err; v.chk_hold = chkh; v.exp_hold = hold;
      return v;
   endfunction

   localparam int NV = 7;
   vec_t        tbl[NV];
   logic [7:0]  fq[$];

   initial begin
      tbl[0] = mk(96'h00FFA501_13000000_00000000,  8, -1, 1,  0,  1, 32'h00000013,  0, 32'h00000013, 0, 1, 0);
      tbl[1] = mk(96'hA5000000_00000000_00000000,  2, -1, 0,  0,  0, 32'h0,         0, 32'h0,        1, 1, 0);
      tbl[2] = mk(96'hA5021300_00009303_10000000, 10, -1, 1,  0,  2, 32'h00000013,  1, 32'h00100393, 0, 1, 0);
      tbl[3] = mk(96'hA5110000_00000000_00000000,  2, -1, 0,  0,  0, 32'h0,         0, 32'h0,        1, 1, 0);
      tbl[4] = mk(96'hA501EFBE_ADDE0000_00000000,  6, -1, 1,  0,  1, 32'hDEADBEEF,  0, 32'hDEADBEEF, 0, 1, 0);
      tbl[5] = mk(96'hA5021300_00000000_00000000,  5,  4, 0,  0,  0, 32'h0,         0, 32'h0,        1, 0, 0);
      tbl[6] = mk(96'hA5100000_00000000_00000000,  2, -1, 1, 16, 16, 32'h33221100, 15, 32'h3322110F, 0, 1, 0);

      // Reset state, during and after reset.
      rx    = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_write", 32'(bus.write), 32'd0);
      chk("rst_addr",  bus.addr_in,    32'd0);
      chk("rst_data",  bus.data,       32'd0);
      chk("rst_hold",  32'(cpu_hold),  32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_error", 32'(error),     32'd0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_busy", 32'(busy),      32'd0);
      chk("idle_hold", 32'(cpu_hold),  32'd0);

      // Table-driven frames.
      for (int r = 0; r < NV; r++) begin
         int bad;
         clear_log();
         fq.delete();
         for (int i = 0; i < tbl[r].n; i++) fq.push_back(tbl[r].bytes[8*(11-i) +: 8]);
         for (int w = 0; w < tbl[r].gen_words; w++) begin
            fq.push_back(8'(w));
            fq.push_back(8'h11);
            fq.push_back(8'h22);
            fq.push_back(8'h33);
         end
`ifdef IMEM_LOADER_CKSUM_EN
         if (tbl[r].add_ck) begin
            logic [7:0] sum;
            int s;
            sum = 8'd0;
            s = 0;
            while (s < fq.size() && fq[s] != 8'hA5) s++;
            for (int i = s + 1; i < fq.size(); i++) sum = sum + fq[i];
            fq.push_back(8'd0 - sum);
         end
`endif
         for (int i = 0; i < fq.size(); i++) send_byte(fq[i], i != tbl[r].bad_stop);
         repeat (20) @(negedge clk);

         chk($sformatf("r%0d_nwrites", r), 32'(wa.size()), 32'(tbl[r].exp_writes));
         if (tbl[r].exp_writes > 0 && wa.size() > 0) begin
            chk($sformatf("r%0d_first_addr", r), wa[0], 32'd0);
            chk($sformatf("r%0d_first_data", r), wd[0], tbl[r].exp_fd);
            chk($sformatf("r%0d_last_addr", r),  wa[wa.size()-1], tbl[r].exp_la);
            chk($sformatf("r%0d_last_data", r),  wd[wd.size()-1], tbl[r].exp_ld);
         end
         bad = 0;
         for (int i = 0; i < wa.size(); i++) if (wa[i] !== 32'(i)) bad++;
         chk($sformatf("r%0d_addr_seq_errs", r), 32'(bad), 32'd0);
         chk($sformatf("r%0d_long_pulses", r), 32'(long_pulses), 32'd0);
         chk($sformatf("r%0d_error", r), 32'(error), 32'(tbl[r].exp_err));
         chk($sformatf("r%0d_busy", r),  32'(busy),  32'd0);
         if (tbl[r].chk_hold) chk($sformatf("r%0d_hold", r), 32'(cpu_hold), 32'(tbl[r].exp_hold));
`ifndef IMEM_LOADER_CKSUM_EN
         if (tbl[r].exp_writes > 0 && !tbl[r].exp_err)
            chk($sformatf("r%0d_hold_fall_lag", r), 32'(hold_fall_cyc - last_write_cyc), 32'd1);
`endif
      end

      // Reset after 6 bytes of a 2-word frame (word 0 is already written).
      clear_log();
      send_byte(8'hA5, 1); send_byte(8'h02, 1);
      send_byte(8'h13, 1); send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
      repeat (3) @(negedge clk);
      chk("mid_busy",    32'(busy),      32'd1);
      chk("mid_hold",    32'(cpu_hold),  32'd1);
      chk("mid_nwrites", 32'(wa.size()), 32'd1);
      reset = 1'b1;
      #1;
      chk("mrst_data",  bus.data,      32'd0);
      chk("mrst_addr",  bus.addr_in,   32'd0);
      chk("mrst_write", 32'(bus.write), 32'd0);
      chk("mrst_hold",  32'(cpu_hold), 32'd0);
      chk("mrst_busy",  32'(busy),     32'd0);
      chk("mrst_error", 32'(error),    32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      clear_log();
      send_byte(8'hA5, 1); send_byte(8'h01, 1);
      send_byte(8'h78, 1); send_byte(8'h56, 1); send_byte(8'h34, 1); send_byte(8'h12, 1);
`ifdef IMEM_LOADER_CKSUM_EN
      send_byte(8'hEB, 1);
`endif
      repeat (20) @(negedge clk);
      chk("fresh_nwrites", 32'(wa.size()), 32'd1);
      if (wa.size() > 0) begin
         chk("fresh_addr", wa[0], 32'd0);
         chk("fresh_data", wd[0], 32'h12345678);
      end
      chk("fresh_hold",  32'(cpu_hold), 32'd0);
      chk("fresh_error", 32'(error),    32'd0);

`ifdef IMEM_LOADER_CKSUM_EN
      // Good checksum releases the core.
      clear_log();
      send_byte(8'hA5, 1); send_byte(8'h01, 1);
      send_byte(8'h13, 1); send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
      send_byte(8'hEC, 1);
      repeat (20) @(negedge clk);
      chk("ck_ok_nwrites", 32'(wa.size()), 32'd1);
      chk("ck_ok_hold",    32'(cpu_hold),  32'd0);
      chk("ck_ok_error",   32'(error),     32'd0);
      // Bad checksum: word written, error set, core stays held.
      clear_log();
      send_byte(8'hA5, 1); send_byte(8'h01, 1);
      send_byte(8'h13, 1); send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
      send_byte(8'hED, 1);
      repeat (20) @(negedge clk);
      chk("ck_bad_nwrites", 32'(wa.size()), 32'd1);
      chk("ck_bad_hold",    32'(cpu_hold),  32'd1);
      chk("ck_bad_error",   32'(error),     32'd1);
      chk("ck_bad_busy",    32'(busy),      32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- UART bootloader that fills the instruction memory through its write port (write, addr_in, data) while the core is held off.
- Receives an 8N1 byte stream, checks a framing header, assembles little-endian 32-bit words and issues one single-cycle write per word.
- Sits between the board RX pin and the imem write port; cpu_hold drives the core's reset/stall.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per UART bit (12 MHz / 115200).
- DEPTH, 16, number of imem words; the maximum legal word count.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx  input  1  UART serial in, idle high, asynchronous to clk
- write  output  1  imem write strobe, one clk cycle per word
- addr_in  output  32  imem word index (not byte address), zero-extended
- data  output  32  word to write, little-endian assembly of 4 received bytes
- cpu_hold  output  1  high while a load is in progress; core must not fetch
- busy  output  1  high in any state other than WAIT_SYNC
- error  output  1  sticky; set on protocol/framing error, cleared by the next valid sync byte or reset

Behaviour:
- Reset values: write=0, addr_in=0, data=0, cpu_hold=0, busy=0, error=0, FSM=WAIT_SYNC, byte counter=0, word counter=0.
- Reset mid-load: everything returns to reset values immediately; partially written imem contents stay as written.
- RX front end: rx goes through a 2-FF synchronizer, reset to 1.
- Start bit: a falling edge starts a half-bit count. If rx is not low at mid-start, it is a false start and the front end returns to idle.
- Data bits: 8 data bits sampled at bit centres, LSB first.
- Stop bit: sampled at its centre. If it is 1, a byte_valid pulse (1 cycle) is issued. If it is 0, a framing error is raised, the byte is dropped, error=1 and the FSM goes to WAIT_SYNC.
- Frame format: sync 0xA5, count N (1..DEPTH), then 4*N payload bytes, then (optional) checksum.
- WAIT_SYNC:
  - 0xA5 -> GET_LEN, with cpu_hold=1, busy=1, error=0.
  - Any other byte is ignored.
- GET_LEN:
  - N==0 or N>DEPTH -> error=1, cpu_hold=0, go to WAIT_SYNC.
  - Otherwise latch N, clear counters, go to GET_DATA.
- GET_DATA:
  - Each byte shifts into bits [8*k+7:8*k], where k is the byte counter 0..3.
  - On the 4th byte, in the cycle after byte_valid: write=1, data={b3,b2,b1,b0}, addr_in=word counter. The word counter then increments.
  - addr_in and data hold their last values while write=0.
  - After word N-1 is written -> DONE (or GET_CKSUM if the option is enabled).
- DONE: cpu_hold=0 and busy=0 one cycle after the last write, then go to WAIT_SYNC.
- A sync byte received mid-payload is treated as data; there is no resynchronisation inside a frame.
- Word counter width is clog2(DEPTH)+1 and never wraps, because N<=DEPTH.
- Only one write can be in flight per byte, so there is no back-pressure.

Optional Feature:
- Macro: IMEM_LOADER_CKSUM_EN.
- With it defined:
  - A GET_CKSUM state follows the payload and expects one byte equal to the 8-bit two's-complement of (N + sum of all payload bytes) mod 256.
  - Match -> DONE.
  - Mismatch -> error=1 and cpu_hold stays 1 until the next valid frame or reset. Words are already written, so the core must not run them.
- Without it: no checksum byte; GET_DATA goes directly to DONE.

Decomposition:
- Package imem_loader_pkg holds:
  - SYNC_BYTE=8'hA5
  - the FSM state enum (WAIT_SYNC, GET_LEN, GET_DATA, GET_CKSUM, DONE)
  - the UART RX state enum (IDLE, START, BITS, STOP)
- Sub-module uart_rx_byte (parameter CLKS_PER_BIT) contains the synchronizer, bit timing and the byte_valid/byte/frame_err outputs.
- imem_loader instantiates uart_rx_byte and holds the framing FSM and word assembly.

Test Plan:
- Frame A5 02 13 00 00 00 93 03 10 00 -> write pulses at addr_in=0 data=0x00000013, then addr_in=1 data=0x00100393. Each pulse lasts exactly 1 cycle; cpu_hold falls 1 cycle after the 2nd write.
- Bytes 00 FF then A5 01 + 4 bytes -> leading garbage ignored; a single write at addr_in=0.
- A5 00, and separately A5 11 (17 > DEPTH) -> no write, error=1, cpu_hold=0; a following valid frame clears error.
- Stop bit forced low on the 3rd payload byte -> error=1, FSM back to WAIT_SYNC, no write for that word.
- Assert reset mid-frame after 6 bytes -> all outputs at reset values; a fresh frame loads correctly.
- With IMEM_LOADER_CKSUM_EN, A5 01 13 00 00 00 + checksum 0xEC -> cpu_hold=0. With checksum 0xED -> error=1 and cpu_hold stays 1.
